// File: rtl/rgmii_pkg.sv
// Speed encodings, nibble-period divider constants and small decode helpers
// shared by the RGMII transmit formatter.
package rgmii_pkg;

   typedef enum logic [1:0] {
      SPEED_10   = 2'b00,
      SPEED_100  = 2'b01,
      SPEED_1000 = 2'b10,
      SPEED_RSVD = 2'b11
   } speed_e;

   localparam int DIV_100 = 5;
   localparam int DIV_10  = 50;
   localparam int CNT_W   = 6;

   // Last cnt value of the half-cycle-high part of the forwarded TXC.
   localparam logic [CNT_W-1:0] CLK100_D1_LAST = CNT_W'(2);
   localparam logic [CNT_W-1:0] CLK100_D2_LAST = CNT_W'(1);
   localparam logic [CNT_W-1:0] CLK10_HALF     = CNT_W'(DIV_10 / 2);

   // The reserved code 2'b11 behaves as gigabit.
   function automatic logic is_gig(input speed_e s);
      return s[1];
   endfunction

   function automatic logic [CNT_W-1:0] div_last(input speed_e s);
      return (s == SPEED_10) ? CNT_W'(DIV_10 - 1) : CNT_W'(DIV_100 - 1);
   endfunction

endpackage

// File: rtl/rgmii_tx_clk_div.sv
// Nibble-period divider for RGMII TX: cnt/ph timing, latched speed, the MAC
// byte strobe and the registered TXC forwarding pattern.
module rgmii_tx_clk_div
   import rgmii_pkg::*;
#(
   parameter logic [1:0] INIT_SPEED = 2'b10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed,
   output logic       strobe,
   output logic       nib_adv,
   output speed_e     spd_nxt,
   output logic       clk_d1,
   output logic       clk_d2
);

   speed_e           spd_q;
   logic [CNT_W-1:0] cnt;
   logic             ph;

   logic [CNT_W-1:0] last;
   logic [CNT_W-1:0] last_n;
   logic             boundary;
   speed_e           spd_n;
   logic [CNT_W-1:0] cnt_n;
   logic             ph_n;
   logic             strobe_n;
   logic             nib_n;
   logic             clk_d1_n;
   logic             clk_d2_n;

   always_comb begin
      last     = div_last(spd_q);
      boundary = is_gig(spd_q) || (cnt == last && ph);
      spd_n    = boundary ? speed_e'(speed) : spd_q;
      cnt_n    = cnt;
      ph_n     = ph;
      // Speed only changes on a byte boundary, so restarting here never cuts a nibble.
      if (is_gig(spd_q) || spd_n != spd_q) begin
         cnt_n = '0;
         ph_n  = 1'b0;
      end else if (cnt == last) begin
         cnt_n = '0;
         ph_n  = ~ph;
      end else begin
         cnt_n = cnt + 1'b1;
      end
      last_n   = div_last(spd_n);
      strobe_n = is_gig(spd_n) || (cnt_n == last_n && ph_n);
      nib_n    = !is_gig(spd_n) && (cnt_n == last_n) && !ph_n;
      case (spd_n)
         SPEED_100: begin
            clk_d1_n = (cnt_n <= CLK100_D1_LAST);
            clk_d2_n = (cnt_n <= CLK100_D2_LAST);
         end
         SPEED_10: begin
            clk_d1_n = (cnt_n < CLK10_HALF);
            clk_d2_n = (cnt_n < CLK10_HALF);
         end
         default: begin
            clk_d1_n = 1'b1;
            clk_d2_n = 1'b0;
         end
      endcase
   end

   assign spd_nxt = spd_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         spd_q   <= speed_e'(INIT_SPEED);
         cnt     <= '0;
         ph      <= 1'b0;
         strobe  <= 1'b0;
         nib_adv <= 1'b0;
         clk_d1  <= 1'b0;
         clk_d2  <= 1'b0;
      end else begin
         spd_q   <= spd_n;
         cnt     <= cnt_n;
         ph      <= ph_n;
         strobe  <= strobe_n;
         nib_adv <= nib_n;
         clk_d1  <= clk_d1_n;
         clk_d2  <= clk_d2_n;
      end
   end

endmodule

// File: rtl/rgmii_tx_ddr_fmt.sv
// GMII-to-RGMII TX formatter producing ODDR d1/d2 data, TX_CTL and TXC.
// Optional RGMII_TX_IDLE_GATE_EN zeroes captured data on idle bytes.
module rgmii_tx_ddr_fmt
   import rgmii_pkg::*;
#(
   parameter logic [1:0] INIT_SPEED = 2'b10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] speed,
   input  logic [7:0] gmii_txd,
   input  logic       gmii_tx_en,
   input  logic       gmii_tx_er,
   output logic       mac_gmii_tx_clk_en,
   output logic [3:0] txd_d1,
   output logic [3:0] txd_d2,
   output logic       ctl_d1,
   output logic       ctl_d2,
   output logic       clk_d1,
   output logic       clk_d2
);

   logic       strobe;
   logic       nib_adv;
   speed_e     spd_nxt;
   logic [7:0] txd_eff;
   logic [3:0] hi_nib;

   rgmii_tx_clk_div #(
      .INIT_SPEED (INIT_SPEED)
   ) u_clk_div (
      .clk     (clk),
      .rst     (rst),
      .speed   (speed),
      .strobe  (strobe),
      .nib_adv (nib_adv),
      .spd_nxt (spd_nxt),
      .clk_d1  (clk_d1),
      .clk_d2  (clk_d2)
   );

   assign mac_gmii_tx_clk_en = strobe;

   always_comb begin
`ifdef RGMII_TX_IDLE_GATE_EN
      txd_eff = (!gmii_tx_en && !gmii_tx_er) ? 8'h00 : gmii_txd;
`else
      txd_eff = gmii_txd;
`endif
   end

   // A byte taken on a boundary edge belongs to the speed latched on that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         txd_d1 <= 4'h0;
         txd_d2 <= 4'h0;
         ctl_d1 <= 1'b0;
         ctl_d2 <= 1'b0;
         hi_nib <= 4'h0;
      end else if (strobe) begin
         txd_d1 <= txd_eff[3:0];
         txd_d2 <= is_gig(spd_nxt) ? txd_eff[7:4] : txd_eff[3:0];
         hi_nib <= txd_eff[7:4];
         ctl_d1 <= gmii_tx_en;
         ctl_d2 <= gmii_tx_en ^ gmii_tx_er;
      end else if (nib_adv) begin
         txd_d1 <= hi_nib;
         txd_d2 <= hi_nib;
      end
   end

endmodule

// File: tb/tb_rgmii_tx_ddr_fmt.sv
// Directed bench for rgmii_tx_ddr_fmt: 1G, 100M, 10M, speed switch and
// mid-byte reset, with hand-computed expected output vectors.
module tb_rgmii_tx_ddr_fmt;

   logic       clk;
   logic       rst;
   logic [1:0] speed;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en;
   logic       gmii_tx_er;
   logic       mac_gmii_tx_clk_en;
   logic [3:0] txd_d1;
   logic [3:0] txd_d2;
   logic       ctl_d1;
   logic       ctl_d2;
   logic       clk_d1;
   logic       clk_d2;

   int checks;
   int failures;

`ifdef RGMII_TX_IDLE_GATE_EN
   localparam logic [3:0] IDLE_NIB = 4'h0;
`else
   localparam logic [3:0] IDLE_NIB = 4'hF;
`endif

   rgmii_tx_ddr_fmt dut (
      .clk                (clk),
      .rst                (rst),
      .speed              (speed),
      .gmii_txd           (gmii_txd),
      .gmii_tx_en         (gmii_tx_en),
      .gmii_tx_er         (gmii_tx_er),
      .mac_gmii_tx_clk_en (mac_gmii_tx_clk_en),
      .txd_d1             (txd_d1),
      .txd_d2             (txd_d2),
      .ctl_d1             (ctl_d1),
      .ctl_d2             (ctl_d2),
      .clk_d1             (clk_d1),
      .clk_d2             (clk_d2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // Vector layout: {strobe, txd_d1, txd_d2, ctl_d1, ctl_d2, clk_d1, clk_d2}
   function automatic logic [12:0] ev(input logic st, input logic [3:0] d1,
                                      input logic [3:0] d2, input logic c1,
                                      input logic c2, input logic k1,
                                      input logic k2);
      return {st, d1, d2, c1, c2, k1, k2};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [12:0] exp_v);
      logic [12:0] obs;
      obs = {mac_gmii_tx_clk_en, txd_d1, txd_d2, ctl_d1, ctl_d2, clk_d1, clk_d2};
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   initial begin
      int c;
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      speed      = 2'b10;
      gmii_txd   = 8'h00;
      gmii_tx_en = 1'b0;
      gmii_tx_er = 1'b0;
      step();
      step();
      chk("reset", 13'h0);

      // Gigabit: strobe every cycle, low nibble on d1, high nibble on d2.
      rst = 1'b0; gmii_txd = 8'hA5; gmii_tx_en = 1'b1;
      step();
      chk("g_first", ev(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0));
      step();
      chk("g_a5", ev(1'b1, 4'h5, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0));
      gmii_txd = 8'h3C; gmii_tx_er = 1'b1;
      step();
      chk("g_3c_er", ev(1'b1, 4'hC, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0));

      // Switch to 100M on a gigabit boundary.
      speed = 2'b01; gmii_tx_er = 1'b0;
      step();
      chk("m100_cap", ev(1'b0, 4'hC, 4'hC, 1'b1, 1'b1, 1'b1, 1'b1));
      gmii_txd = 8'h77; gmii_tx_en = 1'b0;
      for (int k = 1; k < 10; k++) begin
         step();
         c = k % 5;
         chk("m100_cyc", ev(k == 9, (k < 5) ? 4'hC : 4'h3, (k < 5) ? 4'hC : 4'h3,
                            1'b1, 1'b1, c <= 2, c <= 1));
      end
      gmii_txd = 8'hFF; gmii_tx_en = 1'b0; gmii_tx_er = 1'b0;
      step();
      chk("m100_idle", ev(1'b0, IDLE_NIB, IDLE_NIB, 1'b0, 1'b0, 1'b1, 1'b1));

      // Request 10M mid-nibble: 100M timing holds until the byte boundary.
      speed = 2'b00;
      for (int k = 11; k < 20; k++) begin
         step();
         c = k % 5;
         chk("m100_hold", ev(k == 19, IDLE_NIB, IDLE_NIB, 1'b0, 1'b0, c <= 2, c <= 1));
      end
      gmii_txd = 8'h5A; gmii_tx_en = 1'b1; gmii_tx_er = 1'b1;
      step();
      chk("m10_cap", ev(1'b0, 4'hA, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1));
      gmii_txd = 8'h11; gmii_tx_en = 1'b0; gmii_tx_er = 1'b0;
      for (int j = 1; j < 100; j++) begin
         step();
         c = j % 50;
         chk("m10_cyc", ev(j == 99, (j < 50) ? 4'hA : 4'h5, (j < 50) ? 4'hA : 4'h5,
                           1'b1, 1'b0, c < 25, c < 25));
      end

      // Back to 100M, then reset mid-byte at cnt=3, ph=1.
      speed = 2'b01; gmii_txd = 8'hC3; gmii_tx_en = 1'b1; gmii_tx_er = 1'b0;
      step();
      chk("m100_again", ev(1'b0, 4'h3, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1));
      for (int k = 1; k < 9; k++) begin
         step();
         c = k % 5;
         chk("m100_pre_rst", ev(1'b0, (k < 5) ? 4'h3 : 4'hC, (k < 5) ? 4'h3 : 4'hC,
                                1'b1, 1'b1, c <= 2, c <= 1));
      end
      rst = 1'b1;
      step();
      chk("rst_mid", 13'h0);
      rst = 1'b0;
      step();
      chk("rel_first", ev(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1));
      for (int m = 1; m < 10; m++) begin
         step();
         c = m % 5;
         chk("rel_cyc", ev(m == 9, 4'h0, 4'h0, 1'b0, 1'b0, c <= 2, c <= 1));
      end
      gmii_txd = 8'h96; gmii_tx_en = 1'b1; gmii_tx_er = 1'b0;
      step();
      chk("rel_cap", ev(1'b0, 4'h6, 4'h6, 1'b1, 1'b1, 1'b1, 1'b1));

      // Speed code 11 behaves as gigabit once the byte boundary arrives.
      speed = 2'b11;
      for (int m = 11; m < 20; m++) begin
         step();
         c = m % 5;
         chk("rsvd_hold", ev(m == 19, (m < 15) ? 4'h6 : 4'h9, (m < 15) ? 4'h6 : 4'h9,
                             1'b1, 1'b1, c <= 2, c <= 1));
      end
      gmii_txd = 8'h4B;
      step();
      chk("g_rsvd", ev(1'b1, 4'hB, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0));
      step();
      chk("g_rsvd_run", ev(1'b1, 4'hB, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rgmii_tx_ddr_fmt.md
RGMII_TX_DDR_FMT -- requirements
Module: rgmii_tx_ddr_fmt

Interface
REQ-001 SHALL have parameter INIT_SPEED, default 2'b10, giving the speed register value after reset.
REQ-002 SHALL have port clk  input  1  the 125 MHz TX clock; one clock domain only.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port speed  input  2  link speed: 00 = 10M, 01 = 100M, 10 = 1G; 11 is treated as 1G.
REQ-005 SHALL have port gmii_txd  input  8  MAC transmit byte.
REQ-006 SHALL have port gmii_tx_en  input  1  MAC transmit enable.
REQ-007 SHALL have port gmii_tx_er  input  1  MAC transmit error.
REQ-008 SHALL have port mac_gmii_tx_clk_en  output  1  byte-accept strobe; the MAC presents the next byte while this is high.
REQ-009 SHALL have port txd_d1  output  4  ODDR rising-edge data.
REQ-010 SHALL have port txd_d2  output  4  ODDR falling-edge data.
REQ-011 SHALL have ports ctl_d1 and ctl_d2  output  1 each  ODDR rising- and falling-edge TX_CTL.
REQ-012 SHALL have ports clk_d1 and clk_d2  output  1 each  ODDR pattern that forwards TXC.

Function
REQ-013 All outputs SHALL be registered; gmii_* sampled on an edge where mac_gmii_tx_clk_en=1 SHALL appear on the txd_* and ctl_* outputs after that same edge (1-cycle latency).
REQ-014 1G mode: mac_gmii_tx_clk_en=1 every cycle; txd_d1=gmii_txd[3:0], txd_d2=gmii_txd[7:4], ctl_d1=gmii_tx_en, ctl_d2=gmii_tx_en^gmii_tx_er, clk_d1=1, clk_d2=0.
REQ-015 10/100 mode: counter cnt SHALL run 0..N-1 with N=5 (100M) or N=50 (10M); one nibble period is one counter wrap; a nibble-phase bit ph SHALL toggle at each wrap.
REQ-016 10/100 mode: mac_gmii_tx_clk_en=1 for exactly one cycle per byte, in the cycle where cnt=N-1 and ph=1.
REQ-017 10/100 mode, capture edge (strobe high): txd_d1=txd_d2=gmii_txd[3:0]; the high nibble SHALL be stored internally; ctl_d1=gmii_tx_en; ctl_d2=gmii_tx_en^gmii_tx_er.
REQ-018 10/100 mode, at the wrap with ph 0->1: txd_d1=txd_d2=stored high nibble; ctl_* held.
REQ-019 100M clock pattern (d1,d2) by cnt: 0:(1,1), 1:(1,1), 2:(1,0), 3:(0,0), 4:(0,0), giving 50% duty in half-cycles.
REQ-020 10M clock pattern: clk_d1=clk_d2=1 for cnt 0..24 and 0 for cnt 25..49.
REQ-021 The speed input SHALL be latched only at a byte boundary: every cycle in 1G mode, and in 10/100 mode only when cnt=N-1 and ph=1.
REQ-022 When the latched speed changes, cnt and ph SHALL restart at 0 on the next cycle; no partial nibble SHALL be emitted.
REQ-023 A change of gmii_* between strobes SHALL have no effect on the outputs.

Reset
REQ-024 While rst=1 at a clk edge: cnt=0; ph=0; latched speed=INIT_SPEED; txd_*=0; ctl_*=0; clk_d1=clk_d2=0; mac_gmii_tx_clk_en=0.
REQ-025 On the first edge after rst deasserts, normal operation SHALL begin from cnt=0, ph=0.
REQ-026 Reset asserted mid-byte SHALL discard the stored high nibble.

Configuration
REQ-027 With RGMII_TX_IDLE_GATE_EN defined, captured txd SHALL be forced to 4'h0 whenever gmii_tx_en=0 and gmii_tx_er=0.
REQ-028 Without RGMII_TX_IDLE_GATE_EN, gmii_txd SHALL pass through unmodified in all states.

Structure
REQ-029 Package rgmii_pkg SHALL hold the speed encodings (SPEED_10, SPEED_100, SPEED_1000) and the divider constants DIV_100=5 and DIV_10=50.
REQ-030 Sub-module rgmii_tx_clk_div SHALL contain cnt, ph, the strobe and the clk_d1/clk_d2 patterns; the top level SHALL contain the data and ctl muxing.

Verification
REQ-031 1G: speed=10, txd=8'hA5, tx_en=1 -> next cycle txd_d1=5, txd_d2=A, ctl=(1,1), clk=(1,0), strobe constant 1.
REQ-032 100M: byte 8'h3C -> txd_*=C for 5 cycles, then 3 for 5 cycles; strobe period exactly 10 cycles; clk pattern matches REQ-019.
REQ-033 10M: tx_en=1, tx_er=1 -> ctl=(1,0); strobe period 100 cycles; clk high for 25 cycles, low for 25 cycles.
REQ-034 Speed switched 01->00 mid-nibble -> old speed held until the byte boundary, then cnt restarts at 0 with 10M timing.
REQ-035 rst pulsed at cnt=3, ph=1 -> all outputs 0 next cycle; after release the first strobe follows 10M/100M timing from cnt=0.
REQ-036 With RGMII_TX_IDLE_GATE_EN: tx_en=0, tx_er=0, txd=8'hFF -> txd_*=0; without the macro -> txd_d1=txd_d2=F.
